// File: rtl/slicer_mer_estimate.sv
// slicer_mer_estimate
// 4-ASK hard-decision slicer. It produces the decided symbol, the
// reconstructed level and the slicer error for each symbol. It also
// estimates the mean squared slicer error over periods of 2^PERIOD_LOG2
// symbols.
//
// Strobe semantics: the block never applies backpressure, so there is no
// ready signal. Every clk edge where sym_clk_ena is high is one new symbol,
// including consecutive cycles. sym_valid, err_power_valid and
// clear_accumulator are one-cycle pulses that qualify the registered
// outputs next to them. Those outputs hold their values until the next
// pulse.
module slicer_mer_estimate #(
    parameter int DATA_WIDTH  = 18,
    parameter int PERIOD_LOG2 = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sym_clk_ena,
    input  logic [DATA_WIDTH-1:0]   decision_variable,
    input  logic [DATA_WIDTH-1:0]   reference_level,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [1:0]              sym_hat,
    output logic                    sym_valid,
    output logic [DATA_WIDTH-1:0]   recon,
    output logic [DATA_WIDTH-1:0]   error,
    output logic                    clear_accumulator,
    output logic [2*DATA_WIDTH-1:0] err_power,
    output logic                    err_power_valid
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = 2 * DATA_WIDTH;
    localparam int AW = SW + PERIOD_LOG2;

    // Saturation bounds of the 1s17 output format, held at the wider working widths
    localparam logic signed [W+1:0] RECON_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] RECON_MIN = {3'b111, {(W-1){1'b0}}};
    localparam logic signed [W:0]   ERR_MAX   = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0]   ERR_MIN   = {2'b11, {(W-1){1'b0}}};

    localparam logic [PERIOD_LOG2-1:0] CNT_ONE  = PERIOD_LOG2'(1);
    localparam logic [PERIOD_LOG2-1:0] CNT_LAST = '1;

    // Registered state
    logic [1:0]             r_sym_hat;
    logic                   r_sym_valid;
    logic [W-1:0]           r_recon;
    logic [W-1:0]           r_error;
    logic                   r_clear;
    logic [SW-1:0]          r_err_power;
    logic                   r_err_power_valid;
    logic [PERIOD_LOG2-1:0] r_count;
    logic [AW-1:0]          r_acc;

    // Slicer datapath
    logic signed [W:0]   w_dv_x;
    logic signed [W:0]   w_ref_x;
    logic signed [W:0]   w_neg_ref;
    logic [1:0]          w_sym;
    logic signed [W+1:0] w_b_x;
    logic signed [W+1:0] w_b3;
    logic signed [W+1:0] w_recon_wide;
    logic [W-1:0]        w_recon_sat;
    logic signed [W:0]   w_err_wide;
    logic [W-1:0]        w_err_sat;

    // Power-estimate datapath
    logic signed [SW-1:0] w_err_ext;
    logic signed [SW-1:0] w_sq;
    logic [AW-1:0]        w_acc_sum;
    logic                 w_period_end;

    // One extra bit keeps -reference_level exact even for the most negative input
    assign w_dv_x    = {decision_variable[W-1], decision_variable};
    assign w_ref_x   = {reference_level[W-1], reference_level};
    assign w_neg_ref = -w_ref_x;

    // Decision regions; a value on a threshold falls into the upper region
    always_comb begin
        w_sym = 2'b00;
        if (w_dv_x >= w_ref_x) begin
            w_sym = 2'b11;
        end else if (!w_dv_x[W]) begin
            w_sym = 2'b10;
        end else if (w_dv_x >= w_neg_ref) begin
            w_sym = 2'b01;
        end
    end

    // 3b is formed as b + 2b at two extra bits so that it cannot wrap before saturation
    assign w_b_x = {{2{b[W-1]}}, b};
    assign w_b3  = w_b_x + (w_b_x <<< 1);

    // Select the ideal constellation level for the decided symbol
    always_comb begin
        case (w_sym)
            2'b11:   w_recon_wide = w_b3;
            2'b10:   w_recon_wide = w_b_x;
            2'b01:   w_recon_wide = -w_b_x;
            default: w_recon_wide = -w_b3;
        endcase
    end

    // Clamp the reconstructed level into the 1s17 range
    always_comb begin
        if (w_recon_wide > RECON_MAX) begin
            w_recon_sat = RECON_MAX[W-1:0];
        end else if (w_recon_wide < RECON_MIN) begin
            w_recon_sat = RECON_MIN[W-1:0];
        end else begin
            w_recon_sat = w_recon_wide[W-1:0];
        end
    end

    assign w_err_wide = w_dv_x - {w_recon_sat[W-1], w_recon_sat};

    // Clamp the slicer error into the 1s17 range
    always_comb begin
        if (w_err_wide > ERR_MAX) begin
            w_err_sat = ERR_MAX[W-1:0];
        end else if (w_err_wide < ERR_MIN) begin
            w_err_sat = ERR_MIN[W-1:0];
        end else begin
            w_err_sat = w_err_wide[W-1:0];
        end
    end

    // The square of a sign-extended 1s17 value is at most 2^34, so it fits SW bits unsigned
    assign w_err_ext    = {{W{r_error[W-1]}}, r_error};
    assign w_sq         = w_err_ext * w_err_ext;
    assign w_acc_sum    = r_acc + {{PERIOD_LOG2{1'b0}}, w_sq};
    assign w_period_end = (r_count == CNT_LAST);

    // Capture the decision, level and error on each symbol strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sym_hat   <= 2'b00;
            r_sym_valid <= 1'b0;
            r_recon     <= '0;
            r_error     <= '0;
        end else begin
            r_sym_valid <= sym_clk_ena;
            if (sym_clk_ena) begin
                r_sym_hat <= w_sym;
                r_recon   <= w_recon_sat;
                r_error   <= w_err_sat;
            end
        end
    end

    // Accumulate squared error and publish the period mean on the last symbol
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count           <= '0;
            r_acc             <= '0;
            r_err_power       <= '0;
            r_err_power_valid <= 1'b0;
            r_clear           <= 1'b0;
        end else begin
            r_err_power_valid <= 1'b0;
            r_clear           <= 1'b0;
            if (r_sym_valid) begin
                r_count <= r_count + CNT_ONE;
                if (w_period_end) begin
                    r_err_power       <= w_acc_sum[AW-1:PERIOD_LOG2];
                    r_acc             <= '0;
                    r_err_power_valid <= 1'b1;
                    r_clear           <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end
        end
    end

    assign sym_hat           = r_sym_hat;
    assign sym_valid         = r_sym_valid;
    assign recon             = r_recon;
    assign error             = r_error;
    assign clear_accumulator = r_clear;
    assign err_power         = r_err_power;
    assign err_power_valid   = r_err_power_valid;

endmodule

// File: tb/tb_slicer_mer_estimate.sv
// Testbench for slicer_mer_estimate (DATA_WIDTH=18, PERIOD_LOG2=2).
// Directed steps and a randomized run. A monitor compares every cycle
// against an integer reference model of the slicer and of the
// period-mean squared error.
module tb_slicer_mer_estimate;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        sym_clk_ena;
    logic [17:0] decision_variable;
    logic [17:0] reference_level;
    logic [17:0] b;
    logic [1:0]  sym_hat;
    logic        sym_valid;
    logic [17:0] recon;
    logic [17:0] error;
    logic        clear_accumulator;
    logic [35:0] err_power;
    logic        err_power_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    slicer_mer_estimate #(
        .DATA_WIDTH  (18),
        .PERIOD_LOG2 (2)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .sym_clk_ena       (sym_clk_ena),
        .decision_variable (decision_variable),
        .reference_level   (reference_level),
        .b                 (b),
        .sym_hat           (sym_hat),
        .sym_valid         (sym_valid),
        .recon             (recon),
        .error             (error),
        .clear_accumulator (clear_accumulator),
        .err_power         (err_power),
        .err_power_valid   (err_power_valid)
    );

    // ---------------- helpers ----------------
    function automatic logic [17:0] s18(input int v);
        return v[17:0];
    endfunction

    function automatic int clamp(input int v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: 4-ASK regions with ties upward, levels +-b / +-3b, clamped to 1s17
    function automatic void model(input int dv, input int rl, input int bv,
                                  output int s, output int rc, output int er);
        if (dv >= rl)       s = 3;
        else if (dv >= 0)   s = 2;
        else if (dv >= -rl) s = 1;
        else                s = 0;
        case (s)
            3:       rc = 3 * bv;
            2:       rc = bv;
            1:       rc = -bv;
            default: rc = -3 * bv;
        endcase
        rc = clamp(rc);
        er = clamp(dv - rc);
    endfunction

    // ---------------- scoreboard ----------------
    int q_dv[$];
    int q_rl[$];
    int q_b[$];

    int          m_sym = 0;
    int          m_rc  = 0;
    int          m_er  = 0;
    logic [35:0] m_ep  = '0;
    logic [35:0] m_pend_val = '0;
    bit          m_pend = 0;
    longint      m_sum  = 0;
    int          m_n    = 0;

    // Record every accepted symbol
    always @(posedge clk) begin
        if (reset_n === 1'b1 && sym_clk_ena === 1'b1) begin
            q_dv.push_back(int'($signed(decision_variable)));
            q_rl.push_back(int'($signed(reference_level)));
            q_b.push_back(int'($signed(b)));
        end
    end

    // Compare all outputs against the model on every falling edge
    always @(negedge clk) begin
        bit exp_sv;
        bit exp_ev;
        if (reset_n !== 1'b1) begin
            q_dv.delete(); q_rl.delete(); q_b.delete();
            m_sym = 0; m_rc = 0; m_er = 0; m_ep = '0;
            m_pend = 0; m_sum = 0; m_n = 0;
            check("rst_sym_valid", 36'(sym_valid), 36'(0));
            check("rst_recon", 36'(recon), 36'(0));
            check("rst_err_power", err_power, 36'(0));
            check("rst_ep_valid", 36'(err_power_valid), 36'(0));
        end else begin
            exp_ev = m_pend;
            if (m_pend) begin
                m_ep   = m_pend_val;
                m_pend = 0;
            end
            exp_sv = 0;
            if (q_dv.size() > 0) begin
                int s, rc, er;
                model(q_dv.pop_front(), q_rl.pop_front(), q_b.pop_front(), s, rc, er);
                m_sym = s; m_rc = rc; m_er = er;
                exp_sv = 1;
                m_sum += longint'(er) * longint'(er);
                m_n++;
                if (m_n == 4) begin
                    m_pend_val = 36'(m_sum / 4);
                    m_pend     = 1;
                    m_sum      = 0;
                    m_n        = 0;
                end
            end
            check("m_sym_valid", 36'(sym_valid), 36'(exp_sv));
            check("m_sym_hat", 36'(sym_hat), 36'(m_sym[1:0]));
            check("m_recon", 36'(recon), 36'(s18(m_rc)));
            check("m_error", 36'(error), 36'(s18(m_er)));
            check("m_ep_valid", 36'(err_power_valid), 36'(exp_ev));
            check("m_clear_acc", 36'(clear_accumulator), 36'(exp_ev));
            check("m_err_power", err_power, m_ep);
        end
    end

    // ---------------- driver ----------------
    task automatic strobe(input logic [17:0] dv, input logic [17:0] rl, input logic [17:0] bb);
        @(negedge clk);
        decision_variable = dv;
        reference_level   = rl;
        b                 = bb;
        sym_clk_ena       = 1'b1;
        @(negedge clk);
        sym_clk_ena = 1'b0;
    endtask

    task automatic check_sym(input string tag, input logic [1:0] s,
                             input logic [17:0] rc, input logic [17:0] er);
        check({tag, "_sym"}, 36'(sym_hat), 36'(s));
        check({tag, "_recon"}, 36'(recon), 36'(rc));
        check({tag, "_error"}, 36'(error), 36'(er));
    endtask

    localparam logic [17:0] RL = 18'h10000;
    localparam logic [17:0] BD = 18'h08000;

    // ---------------- stimulus ----------------
    initial begin
        logic [17:0] bb_dv[4];
        int sv_cnt;
        int ev_cnt;

        sym_clk_ena       = 1'b0;
        decision_variable = '0;
        reference_level   = RL;
        b                 = BD;
        reset_n           = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_err_power", err_power, 36'(0));
        check("reset_sym_valid", 36'(sym_valid), 36'(0));
        reset_n = 1'b1;

        // Mean squared error over one period of four identical errors
        for (int i = 0; i < 4; i++) begin
            strobe(18'h0C000, RL, BD);
            check_sym("mse", 2'b10, 18'h08000, 18'h04000);
            check("mse_no_ev_yet", 36'(err_power_valid), 36'(0));
        end
        @(negedge clk);
        check("mse_ev", 36'(err_power_valid), 36'(1));
        check("mse_clr", 36'(clear_accumulator), 36'(1));
        check("mse_value", err_power, 36'h010000000);
        @(negedge clk);
        check("mse_ev_one_clk", 36'(err_power_valid), 36'(0));
        check("mse_clr_one_clk", 36'(clear_accumulator), 36'(0));
        check("mse_hold", err_power, 36'h010000000);

        // Slicing examples
        strobe(18'h0C000, RL, BD);
        check_sym("slc_a", 2'b10, 18'h08000, 18'h04000);
        strobe(18'h1FFFF, RL, BD);
        check_sym("slc_b", 2'b11, 18'h18000, 18'h07FFF);
        strobe(s18(-32'h13333), RL, BD);
        check_sym("slc_c", 2'b00, s18(-32'h18000), 18'h04CCD);

        // Thresholds
        strobe(18'h10000, RL, BD);
        check("thr_pos_ref", 36'(sym_hat), 36'(2'b11));
        strobe(18'h00000, RL, BD);
        check("thr_zero", 36'(sym_hat), 36'(2'b10));
        strobe(s18(-32'h10000), RL, BD);
        check("thr_neg_ref", 36'(sym_hat), 36'(2'b01));
        strobe(s18(-32'h10001), RL, BD);
        check("thr_below", 36'(sym_hat), 36'(2'b00));

        // Level saturation
        strobe(18'h1FFFF, RL, 18'h1FFFF);
        check_sym("sat_pos", 2'b11, 18'h1FFFF, 18'h00000);
        strobe(s18(-32'h20000), RL, 18'h1FFFF);
        check_sym("sat_neg", 2'b00, s18(-32'h20000), 18'h00000);

        // Zero reference level never yields the inner negative symbol
        strobe(s18(-1), 18'h00000, BD);
        check_sym("ref0_neg", 2'b00, s18(-32'h18000), 18'h17FFF);
        strobe(18'h00000, 18'h00000, BD);
        check_sym("ref0_zero", 2'b11, 18'h18000, s18(-32'h18000));

        // Reset mid-period discards the partial sum
        strobe(18'h1FFFF, RL, BD);
        strobe(18'h1FFFF, RL, BD);
        #2 reset_n = 1'b0;
        #1;
        check("arst_sym_valid", 36'(sym_valid), 36'(0));
        check("arst_recon", 36'(recon), 36'(0));
        check("arst_error", 36'(error), 36'(0));
        check("arst_sym_hat", 36'(sym_hat), 36'(0));
        check("arst_err_power", err_power, 36'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) strobe(18'h0C000, RL, BD);
        @(negedge clk);
        check("arst_no_ev_after_3", 36'(err_power_valid), 36'(0));
        strobe(18'h0C000, RL, BD);
        @(negedge clk);
        check("arst_ev_after_4", 36'(err_power_valid), 36'(1));
        check("arst_value", err_power, 36'h010000000);

        // Back-to-back strobes
        bb_dv[0] = 18'h0C000;
        bb_dv[1] = 18'h1FFFF;
        bb_dv[2] = s18(-32'h13333);
        bb_dv[3] = 18'h04000;
        sv_cnt = 0;
        ev_cnt = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            decision_variable = bb_dv[i];
            sym_clk_ena = 1'b1;
            @(negedge clk);
            sv_cnt += int'(sym_valid);
            ev_cnt += int'(err_power_valid);
        end
        sym_clk_ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sv_cnt += int'(sym_valid);
            ev_cnt += int'(err_power_valid);
        end
        check("b2b_sym_valid_count", 36'(sv_cnt), 36'(4));
        check("b2b_ep_valid_count", 36'(ev_cnt), 36'(1));

        // Randomized symbols, gaps and levels
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            decision_variable = 18'($urandom());
            reference_level   = ($urandom_range(0, 3) == 0) ? 18'h0 : 18'($urandom_range(1, 18'h1FFFF));
            b                 = 18'($urandom_range(0, 18'h1FFFF));
            sym_clk_ena       = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        sym_clk_ena = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slicer_mer_estimate.md
SLICER_MER_ESTIMATE -- requirements
Module: slicer_mer_estimate

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18: width of all 1s17 sample ports.
REQ-002 SHALL have parameter PERIOD_LOG2, default 20: log2 of symbols per measurement period.
REQ-003 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sym_clk_ena, input, 1: one-clk-wide symbol strobe; may be high on consecutive cycles.
REQ-006 SHALL have port decision_variable, input, DATA_WIDTH: signed 1s17 receiver sample.
REQ-007 SHALL have port reference_level, input, DATA_WIDTH: signed 1s17 outer decision threshold (2d).
REQ-008 SHALL have port b, input, DATA_WIDTH: signed 1s17 inner level magnitude (d).
REQ-009 SHALL have port sym_hat, output, 2: decided 4-ASK symbol: 00=-3d, 01=-d, 10=+d, 11=+3d.
REQ-010 SHALL have port sym_valid, output, 1: one-clk pulse marking new sym_hat/recon/error.
REQ-011 SHALL have port recon, output, DATA_WIDTH: signed 1s17 reconstructed level.
REQ-012 SHALL have port error, output, DATA_WIDTH: signed 1s17 decision_variable minus recon.
REQ-013 SHALL have port clear_accumulator, output, 1: one-clk pulse ending each period, drives the magnitude estimator.
REQ-014 SHALL have port err_power, output, 2*DATA_WIDTH: unsigned 2s34 mean squared error of last period.
REQ-015 SHALL have port err_power_valid, output, 1: one-clk pulse when err_power updates.

Function
REQ-016 SHALL, on a clk edge with sym_clk_ena=1, register sym_hat, recon, error from the current inputs and set sym_valid=1 for the following clk cycle only.
REQ-017 SHALL slice: dv >= reference_level -> 11; 0 <= dv < reference_level -> 10; -reference_level <= dv < 0 -> 01; dv < -reference_level -> 00 (ties go to the upper region).
REQ-018 SHALL produce recon = +b, -b, +3b, -3b per sym_hat, computing 3b as b + (b<<1) at DATA_WIDTH+2 bits, then saturating to [-2^17, 2^17-1].
REQ-019 SHALL compute error at DATA_WIDTH+1 bits and saturate to [-2^17, 2^17-1].
REQ-020 SHALL hold sym_hat, recon, error between strobes.
REQ-021 SHALL, on each clk with sym_valid=1, add error*error (2s34, 2*DATA_WIDTH bits unsigned) into an unsigned accumulator of 2*DATA_WIDTH+PERIOD_LOG2 bits that cannot overflow.
REQ-022 SHALL count sym_valid pulses in a PERIOD_LOG2-bit counter that wraps from 2^PERIOD_LOG2-1 to 0.
REQ-023 SHALL, on the sym_valid cycle where the counter equals 2^PERIOD_LOG2-1:
  - load err_power with (accumulator + current square) >> PERIOD_LOG2;
  - restart the accumulator at 0;
  - pulse err_power_valid and clear_accumulator for the next clk cycle.
REQ-024 SHALL hold err_power between updates; the first update occurs after exactly 2^PERIOD_LOG2 strobes following reset.
REQ-025 SHALL treat sym_clk_ena on consecutive clks as independent symbols with no loss; total latency strobe to err_power_valid on the final symbol is 2 clks.
REQ-026 SHALL, when reference_level = 0, never output 01 (dv<0 -> 00, dv>=0 -> 11).

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force all outputs, the counter and the accumulator to 0.
REQ-028 SHALL, on reset mid-period, discard partial accumulation; the next period starts at the first strobe after release.

Verification (DATA_WIDTH=18, PERIOD_LOG2=2, reference_level=0x10000, b=0x08000)
REQ-029 SHALL test slicing:
  - dv=0x0C000 -> sym_hat=10, recon=0x08000, error=0x04000;
  - dv=0x1FFFF -> 11, recon=0x18000, error=0x07FFF;
  - dv=-0x13333 -> 00, recon=-0x18000, error=+0x04CCD.
REQ-030 SHALL test thresholds: dv=0x10000 -> 11; dv=0 -> 10; dv=-0x10000 -> 01; dv=-0x10001 -> 00.
REQ-031 SHALL test MSE: four strobes each giving error=0x04000 -> err_power=0x10000000; err_power_valid and clear_accumulator high exactly one clk, 1 clk after the 4th sym_valid.
REQ-032 SHALL test saturation: b=0x1FFFF, dv=0x1FFFF -> recon=0x1FFFF, error=0; b=0x1FFFF, dv=-0x20000 -> recon=-0x20000, error=0.
REQ-033 SHALL test back-to-back: sym_clk_ena high 4 consecutive clks -> 4 sym_valid pulses and one err_power update.
REQ-034 SHALL test reset: reset_n low after 2 strobes -> outputs 0 immediately; after release, 4 more strobes are needed for err_power_valid.
